// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO. Frames are sent back-to-back while
// bytes are queued. The frame format is captured when each byte leaves the FIFO.
module uart_tx_fifo #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           data_length,
  input  logic [1:0]           parity_type,
  input  logic                 stop_bits,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 data_out,
  output logic                 p_parity_out,
  output logic                 tx_active,
  output logic                 tx_done,
  output logic [CNT_WIDTH-1:0] fifo_count
);
  localparam int PTR_WIDTH = CNT_WIDTH - 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [DIV_WIDTH-1:0] baud_cnt, baud_cnt_n, baud_reload, baud_reload_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [7:0]           shift, shift_n;
  logic [1:0]           frame_len, frame_len_n;
  logic                 par_en, par_en_n, two_stop, two_stop_n;
  logic                 par_bit, par_bit_n;
  logic                 data_out_n, tx_done_n;
  logic [7:0]           head_masked;

  assign s_ready      = rst && (fifo_count < CNT_WIDTH'(FIFO_DEPTH));
  assign push         = s_valid && s_ready;
  assign tx_active    = (state != IDLE);
  assign p_parity_out = par_bit;

  // Bits above the selected length are cleared so they never reach the line or the parity.
  always_comb begin
    head_masked = mem[rd_ptr];
    case (data_length)
      2'b00:   head_masked = mem[rd_ptr] & 8'h1F;
      2'b01:   head_masked = mem[rd_ptr] & 8'h3F;
      2'b10:   head_masked = mem[rd_ptr] & 8'h7F;
      default: head_masked = mem[rd_ptr];
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_n       = state;
    baud_cnt_n    = baud_cnt;
    baud_reload_n = baud_reload;
    bit_idx_n     = bit_idx;
    shift_n       = shift;
    frame_len_n   = frame_len;
    par_en_n      = par_en;
    two_stop_n    = two_stop;
    par_bit_n     = par_bit;
    data_out_n    = data_out;
    tx_done_n     = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: pop = (fifo_count != '0);
      START: begin
        if (baud_cnt == '0) begin
          state_n    = DATA;
          baud_cnt_n = baud_reload;
          bit_idx_n  = '0;
          data_out_n = shift[0];
        end else baud_cnt_n = baud_cnt - 1'b1;
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_n = baud_reload;
          if (bit_idx == 3'd4 + {1'b0, frame_len}) begin
            bit_idx_n = '0;
            if (par_en) begin
              state_n    = PARITY;
              data_out_n = par_bit;
            end else begin
              state_n    = STOP;
              data_out_n = 1'b1;
            end
          end else begin
            bit_idx_n  = bit_idx + 1'b1;
            shift_n    = shift >> 1;
            data_out_n = shift[1];
          end
        end else baud_cnt_n = baud_cnt - 1'b1;
      end
      PARITY: begin
        if (baud_cnt == '0) begin
          state_n    = STOP;
          baud_cnt_n = baud_reload;
          bit_idx_n  = '0;
          data_out_n = 1'b1;
        end else baud_cnt_n = baud_cnt - 1'b1;
      end
      STOP: begin
        if (baud_cnt == '0) begin
          if (two_stop && bit_idx == '0) begin
            bit_idx_n  = 3'd1;
            baud_cnt_n = baud_reload;
          end else begin
            tx_done_n = 1'b1;
            if (fifo_count != '0) pop = 1'b1;
            else state_n = IDLE;
          end
        end else baud_cnt_n = baud_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // Popping a byte always starts a fresh frame, whether from IDLE or the final stop cycle.
    if (pop) begin
      state_n       = START;
      data_out_n    = 1'b0;
      baud_cnt_n    = baud_div;
      baud_reload_n = baud_div;
      bit_idx_n     = '0;
      shift_n       = head_masked;
      frame_len_n   = data_length;
      par_en_n      = (parity_type == 2'b01) || (parity_type == 2'b10);
      two_stop_n    = stop_bits;
      par_bit_n     = (^head_masked) ^ (parity_type == 2'b01);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      baud_reload <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_len   <= '0;
      par_en      <= 1'b0;
      two_stop    <= 1'b0;
      par_bit     <= 1'b0;
      data_out    <= 1'b1;
      tx_done     <= 1'b0;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_cnt_n;
      baud_reload <= baud_reload_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      frame_len   <= frame_len_n;
      par_en      <= par_en_n;
      two_stop    <= two_stop_n;
      par_bit     <= par_bit_n;
      data_out    <= data_out_n;
      tx_done     <= tx_done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based model of the expected per-cycle line waveform
// is compared every cycle, alongside directed frames with hand-computed expectations.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = '0;
  logic [1:0]  data_length = '0;
  logic [1:0]  parity_type = '0;
  logic        stop_bits = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, data_out, p_parity_out, tx_active, tx_done;
  logic [2:0]  fifo_count;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx_fifo #(.DIV_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(3)) dut (
    .clock(clock), .rst(rst), .baud_div(baud_div), .data_length(data_length),
    .parity_type(parity_type), .stop_bits(stop_bits), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .data_out(data_out),
    .p_parity_out(p_parity_out), .tx_active(tx_active), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the queued bytes plus the remaining per-cycle line values of the current frame.
  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         m_done = 1'b0;
  bit         m_parity = 1'b0;

  task automatic start_frame(input logic [7:0] b);
    bit bits[$];
    bit even = 1'b0;
    int n = 5 + int'(data_length);
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(b[i]);
      even ^= b[i];
    end
    if (parity_type == 2'b01) bits.push_back(!even);
    else if (parity_type == 2'b10) bits.push_back(even);
    m_parity = (parity_type == 2'b01) ? !even : even;
    bits.push_back(1'b1);
    if (stop_bits) bits.push_back(1'b1);
    foreach (bits[k]) repeat (int'(baud_div) + 1) m_wave.push_back(bits[k]);
  endtask

  always @(posedge clock or negedge rst) begin
    bit push_ok;
    if (!rst) begin
      m_q.delete();
      m_wave.delete();
      m_done = 1'b0;
      m_parity = 1'b0;
    end else begin
      m_done = 1'b0;
      push_ok = s_valid && (m_q.size() < DEPTH);
      if (m_wave.size() > 0) begin
        m_wave.delete(0);
        if (m_wave.size() == 0) m_done = 1'b1;
      end
      if (m_wave.size() == 0 && m_q.size() > 0) start_frame(m_q.pop_front());
      if (push_ok) m_q.push_back(s_data);
    end
  end

  always @(negedge clock) begin
    check_output("data_out", data_out, (m_wave.size() > 0) ? int'(m_wave[0]) : 1);
    check_output("tx_active", tx_active, int'(m_wave.size() > 0));
    check_output("tx_done", tx_done, m_done);
    check_output("fifo_count", fifo_count, m_q.size());
    check_output("s_ready", s_ready, int'(rst && m_q.size() < DEPTH));
    check_output("p_parity_out", p_parity_out, m_parity);
  end

  int mon_active = 0;
  int mon_done = 0;
  int mon_falls = 0;
  bit prev_active = 1'b0;

  always @(negedge clock) begin
    if (tx_active) mon_active++;
    if (tx_done) mon_done++;
    if (prev_active && !tx_active) mon_falls++;
    prev_active = tx_active;
  end

  task automatic set_config(input int len, input int par, input int stp, input int baud);
    data_length = 2'(len);
    parity_type = 2'(par);
    stop_bits   = 1'(stp);
    baud_div    = 16'(baud);
  endtask

  // Leaves s_valid high so consecutive calls push on back-to-back cycles.
  task automatic apply_stimulus(input logic [7:0] b);
    bit ok = 1'b0;
    s_data  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      ok = s_ready;
      @(posedge clock);
      #2;
    end
    if (!ok) check_output("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit idle = 1'b0;
    for (int i = 0; i < limit && !idle; i++) begin
      @(negedge clock);
      idle = !tx_active && fifo_count == 0;
    end
    if (!idle) check_output("idle_timeout", 0, 1);
    @(posedge clock);
    #2;
  endtask

  task automatic run_frame(input string name, input int cycles_exp, input logic [11:0] bits_exp,
                           input int nbits, input int baud, input int par_exp);
    bit rec[$];
    bit seen = 1'b0;
    logic [11:0] got = '0;
    int cycles = 0;
    s_valid = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = tx_active;
    end
    if (!seen) check_output({name, "_start_timeout"}, 0, 1);
    while (tx_active && cycles < 1000) begin
      rec.push_back(data_out);
      cycles++;
      @(negedge clock);
    end
    check_output({name, "_done_pulse"}, tx_done, 1);
    check_output({name, "_cycles"}, cycles, cycles_exp);
    for (int k = 0; k < nbits; k++)
      if (k * (baud + 1) < rec.size()) got[k] = rec[k * (baud + 1)];
    check_output({name, "_bits"}, int'(got), int'(bits_exp));
    check_output({name, "_parity"}, p_parity_out, par_exp);
    @(posedge clock);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2;
    check_output("reset_data_out", data_out, 1);
    check_output("reset_tx_active", tx_active, 0);
    check_output("reset_fifo_count", fifo_count, 0);
    check_output("reset_s_ready", s_ready, 0);
    rst = 1'b1;
    @(posedge clock);
    #2;

    set_config(3, 0, 0, 3);
    apply_stimulus(8'hA5);
    run_frame("8N1_A5", 40, 12'h34A, 10, 3, 0);

    set_config(2, 2, 1, 0);
    apply_stimulus(8'h93);
    run_frame("7E2_93", 11, 12'h726, 11, 0, 1);

    set_config(0, 1, 0, 1);
    apply_stimulus(8'hFF);
    run_frame("5O1_FF", 16, 12'h0BE, 8, 1, 0);

    set_config(3, 0, 0, 7);
    mon_active = 0;
    mon_done = 0;
    mon_falls = 0;
    for (int i = 0; i < 6; i++) apply_stimulus(8'(8'h31 + 8'(i)));
    s_valid = 1'b0;
    wait_idle(1000);
    check_output("burst_active_cycles", mon_active, 480);
    check_output("burst_done_pulses", mon_done, 6);
    check_output("burst_active_falls", mon_falls, 1);

    set_config(3, 0, 0, 3);
    apply_stimulus(8'h5A);
    s_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clock);
        seen = tx_active;
      end
      if (!seen) check_output("abort_start_timeout", 0, 1);
    end
    repeat (17) @(negedge clock);
    mon_done = 0;
    #1;
    rst = 1'b0;
    #1;
    check_output("abort_data_out", data_out, 1);
    check_output("abort_tx_active", tx_active, 0);
    check_output("abort_fifo_count", fifo_count, 0);
    check_output("abort_s_ready", s_ready, 0);
    repeat (3) @(posedge clock);
    #2;
    rst = 1'b1;
    repeat (10) @(posedge clock);
    #2;
    check_output("abort_no_done", mon_done, 0);
    apply_stimulus(8'h3C);
    run_frame("after_abort_3C", 40, 12'h278, 10, 3, 0);

    set_config(3, 0, 0, 1);
    mon_active = 0;
    mon_done = 0;
    mon_falls = 0;
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    s_valid = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    set_config(3, 2, 1, 1);
    wait_idle(200);
    check_output("cfg_change_active_cycles", mon_active, 44);
    check_output("cfg_change_done_pulses", mon_done, 2);
    check_output("cfg_change_falls", mon_falls, 1);

    for (int c = 0; c < 1500; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        set_config($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 2));
      @(posedge clock);
      #2;
    end
    s_valid = 1'b0;
    wait_idle(2000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
